// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern generator and its detector partners.
package serial_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_PAT_W = 4;
  localparam logic [3:0] PAT_1001 = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP,
    DONE  = ST_DONE
  } state_t;
endpackage

// File: rtl/piso_shift.sv
// Parallel-load, shift-left register; the MSB is the bit currently on the line.
module piso_shift #(
  parameter int PAT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic [PAT_W-1:0] q,
  output logic             msb
);
  always_ff @(posedge clock) begin
    if (reset)      q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {q[PAT_W-2:0], 1'b0};
  end

  assign msb = q[PAT_W-1];
endmodule

// File: rtl/serial_pattern_gen.sv
// Serializes a latched pattern MSB-first, with repeat count and inter-frame gap.
module serial_pattern_gen
  import serial_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_n,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);
  localparam int BW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat_q, load_val, sr_q;
  logic [CNT_W-1:0] rep_cnt, rep_nx;
  logic [GAP_W-1:0] gap_q, gap_cnt, gap_nx;
  logic [BW-1:0]    bit_cnt, bit_nx;
  logic             load, shift, latch, sr_msb, msb_nx;

  piso_shift #(.PAT_W(PAT_W)) u_sr (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (load_val),
    .q     (sr_q),
    .msb   (sr_msb)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    latch    = 1'b0;
    load_val = pat_q;
    bit_nx   = bit_cnt;
    rep_nx   = rep_cnt;
    gap_nx   = gap_cnt;
    case (state)
      IDLE, DONE: begin
        // DONE accepts start like IDLE so transfers can run back-to-back
        if (start) begin
          latch    = 1'b1;
          load     = 1'b1;
          load_val = pattern;
          bit_nx   = '0;
          rep_nx   = repeat_n;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (bit_cnt == LAST) begin
          if (rep_cnt == '0) begin
            state_nx = DONE;
          end else begin
            rep_nx = rep_cnt - CNT_W'(1);
            bit_nx = '0;
            if (gap_q != '0) begin
              state_nx = GAP;
              gap_nx   = gap_q;
            end else begin
              load = 1'b1;
            end
          end
        end else begin
          shift  = 1'b1;
          bit_nx = bit_cnt + BW'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_nx = SHIFT;
          load     = 1'b1;
          bit_nx   = '0;
        end else begin
          gap_nx = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next line bit, so ser_out can be a plain flop rather than decoded logic
  assign msb_nx = load  ? load_val[PAT_W-1] :
                  shift ? sr_q[PAT_W-2]     : sr_msb;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pat_q       <= '0;
      gap_q       <= '0;
      rep_cnt     <= '0;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state   <= state_nx;
      rep_cnt <= rep_nx;
      gap_cnt <= gap_nx;
      bit_cnt <= bit_nx;
      if (latch) begin
        pat_q <= pattern;
        gap_q <= gap_n;
      end
      ser_valid   <= (state_nx == SHIFT);
      ser_out     <= (state_nx == SHIFT) & msb_nx;
      frame_start <= (state_nx == SHIFT) & load;
      busy        <= (state_nx == SHIFT) | (state_nx == GAP);
      done        <= (state_nx == DONE);
    end
  end
endmodule
